// File: rtl/seq_link_pkg.sv
// Shared definitions for the serial link: FSM state encoding, default sync
// pattern and idle line level, plus a small constant helper.
package seq_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } link_state_t;

  localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1101;
  localparam logic       IDLE_BIT_DEFAULT = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_tx_sync_1101_if.sv
// Handshake + serial line bundle for seq_tx_sync_1101.
//   in_valid/in_data : word offered by the producer
//   in_ready         : transmitter can accept a word this cycle
//   tx_bit/tx_en     : serial line and its frame qualifier
//   frame_done       : pulse with the last frame bit
// master = producer/observer side, slave = transmitter side.
interface seq_tx_sync_1101_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_en;
  logic              frame_done;

  modport master (output in_valid, in_data,
                  input  in_ready, tx_bit, tx_en, frame_done);
  modport slave  (input  in_valid, in_data,
                  output in_ready, tx_bit, tx_en, frame_done);
endinterface

// File: rtl/seq_tx_sync_1101_piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB-first.
//   clk, rst (sync, active-low)
//   load  : capture din (has priority over shift)
//   shift : move left by one, zero fill
//   msb   : current MSB, the next bit to go out
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst)       sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign msb = sr[W-1];
endmodule

// File: rtl/seq_tx_sync_1101.sv
// Serial frame transmitter: accepts a word over valid/ready, sends the sync
// pattern then the payload MSB-first, one bit per clk, on tx_bit with tx_en
// framing it. frame_done pulses with the last bit.
//   clk, rst (sync, active-low)
//   bus (slave): in_valid, in_data, in_ready, tx_bit, tx_en, frame_done
// Build option: SEQ_TX_PARITY_EN appends an even-parity bit (^payload).
//
// The bit on tx_bit is loaded on the same edge that moves the FSM, so the
// state register always names the part of the frame currently on the line.
// The accepting edge therefore already drives the first sync bit, and the
// FSM returns to IDLE on the edge that retires the last bit, which yields a
// single idle cycle between back-to-back frames.
module seq_tx_sync_1101
  import seq_link_pkg::*;
#(
  parameter int               DATA_W   = 8,
  parameter int               SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEFAULT,
  parameter logic             IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  seq_tx_sync_1101_if.slave bus
);
  localparam int CNT_W = $clog2(max2(SYNC_W, DATA_W) + 1);

  link_state_t      state;
  logic [CNT_W-1:0] cnt;     // bits of the current state already on the line
  logic             tx_bit_q, tx_en_q, done_q;
  logic             accept, sync_last, data_last, shift, data_msb, sync_bit;
`ifdef SEQ_TX_PARITY_EN
  logic             par_q;
`endif

  assign bus.in_ready = (state == IDLE) && rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sync_last    = (cnt == CNT_W'(SYNC_W));
  assign data_last    = (cnt == CNT_W'(DATA_W));
  // Payload shifts whenever its MSB is being sent: on the SYNC->DATA edge
  // and on every DATA edge until all bits are out.
  assign shift        = ((state == SYNC) && sync_last) ||
                        ((state == DATA) && !data_last);

  // Sync bit selected from the constant pattern by the bit count.
  always_comb begin
    sync_bit = 1'b0;
    for (int i = 0; i < SYNC_W; i++)
      if (cnt == CNT_W'(i)) sync_bit = SYNC_PAT[SYNC_W-1-i];
  end

  piso_shift_reg #(.W(DATA_W)) u_payload (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift),
    .din   (bus.in_data),
    .msb   (data_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_bit_q <= IDLE_BIT;
      tx_en_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state    <= SYNC;
          cnt      <= CNT_W'(1);
          tx_bit_q <= SYNC_PAT[SYNC_W-1];
          tx_en_q  <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
          par_q    <= ^bus.in_data;
`endif
        end
        SYNC: if (sync_last) begin
          state    <= DATA;
          cnt      <= CNT_W'(1);
          tx_bit_q <= data_msb;
        end else begin
          cnt      <= cnt + CNT_W'(1);
          tx_bit_q <= sync_bit;
        end
        DATA: if (data_last) begin
`ifdef SEQ_TX_PARITY_EN
          state    <= PAR;
          cnt      <= CNT_W'(1);
          tx_bit_q <= par_q;
          done_q   <= 1'b1;
`else
          state    <= IDLE;
          cnt      <= '0;
          tx_bit_q <= IDLE_BIT;
          tx_en_q  <= 1'b0;
`endif
        end else begin
          cnt      <= cnt + CNT_W'(1);
          tx_bit_q <= data_msb;
`ifndef SEQ_TX_PARITY_EN
          done_q   <= (cnt == CNT_W'(DATA_W-1));
`endif
        end
        PAR: begin
          state    <= IDLE;
          cnt      <= '0;
          tx_bit_q <= IDLE_BIT;
          tx_en_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_en      = tx_en_q;
  assign bus.frame_done = done_q;
endmodule
